// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a 4-entry byte FIFO.
// Frames go out back to back while the FIFO holds data; all outputs are registered.
module uart_transmit #(
  parameter int unsigned CLK_HZ = 5_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] dataIn,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       finished_send,
  output logic       overflow
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned TW    = ($clog2(DIV) > 10) ? $clog2(DIV) : 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned PW    = 2;
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          push, pop, bit_done, tx_next, fin_next;

  // Next-state, FIFO handshake and next output values
  always_comb begin
    state_next = state;
    timer_next = timer + TW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    bit_done   = (timer == DIV_LAST);
    push       = send && (count != CNT_FULL);

    case (state)
      IDLE: begin
        timer_next = '0;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[head];
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_next = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_next = '0;
          // Chain straight into the next frame when data is waiting
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[head];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase

    count_next = count + CW'(push) - CW'(pop);

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase

    fin_next = (state_next == STOP) && (timer_next == DIV_LAST);
  end

  // FSM state, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      full          <= 1'b0;
      finished_send <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bit_idx       <= bit_next;
      shift         <= shift_next;
      tx            <= tx_next;
      busy          <= (state_next != IDLE);
      full          <= (count_next == CNT_FULL);
      finished_send <= fin_next;
      if (send && (count == CNT_FULL)) overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push) mem[tail] <= dataIn;
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: reset, latency, bit timing, burst/full/overflow,
// mid-frame reset and a bench-side serial receiver for loopback.
module tb_uart_transmit;

  localparam int DIV   = 5_000_000 / 9600;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       send;
  logic       tx, busy, full, finished_send, overflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_bytes [5];

  uart_transmit dut (
    .clock(clk), .reset_n(reset_n), .dataIn(data_in), .send(send),
    .tx(tx), .busy(busy), .full(full), .finished_send(finished_send), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the sampling point of frame cycle 0; checks n back-to-back frames
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      int bad_tx = 0, bad_busy = 0, fin_cnt = 0, fin_pos = -1;
      for (int c = 0; c < FRAME; c++) begin
        int p = c / DIV;
        logic e;
        if (p == 0)      e = 1'b0;
        else if (p == 9) e = 1'b1;
        else             e = exp_bytes[f][p-1];
        if (tx !== e) bad_tx++;
        if (busy !== 1'b1) bad_busy++;
        if (finished_send === 1'b1) begin fin_cnt++; fin_pos = c; end
        @(negedge clk);
      end
      chk($sformatf("frame%0d_tx_errs", f), 32'(bad_tx), 32'd0);
      chk($sformatf("frame%0d_busy_errs", f), 32'(bad_busy), 32'd0);
      chk($sformatf("frame%0d_fin_cnt", f), 32'(fin_cnt), 32'd1);
      chk($sformatf("frame%0d_fin_pos", f), 32'(fin_pos), 32'(FRAME - 1));
    end
    chk("post_frames_tx", 32'(tx), 32'd1);
    chk("post_frames_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    int cnt;
    logic [7:0] rx;
    logic fin_seen;

    // Reset
    reset_n = 1'b0; send = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_fin", 32'(finished_send), 32'd0);
    end

    // Single byte 0xA5: tx falls one edge after send is sampled
    send = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    chk("lat_edge_k_tx", 32'(tx), 32'd1);
    send = 1'b0;
    @(negedge clk);
    chk("lat_edge_k1_tx", 32'(tx), 32'd0);
    exp_bytes[0] = 8'hA5;
    frames(1);

    // Burst: first byte pops at once, next four fill the FIFO, 0x77 overflows
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h55;
    exp_bytes[3] = 8'h0F; exp_bytes[4] = 8'hC3;
    send = 1'b1; data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    @(negedge clk);
    fork
      frames(5);
      begin
        data_in = 8'h55;
        @(negedge clk); data_in = 8'h0F;
        @(negedge clk); data_in = 8'hC3;
        @(negedge clk);
        chk("burst_full_set", 32'(full), 32'd1);
        chk("burst_ovf_clear", 32'(overflow), 32'd0);
        data_in = 8'h77;
        @(negedge clk);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_full_held", 32'(full), 32'd1);
        send = 1'b0;
        repeat (FRAME - 1 - 4) @(negedge clk);
        chk("full_before_pop", 32'(full), 32'd1);
        @(negedge clk);
        chk("full_after_pop", 32'(full), 32'd0);
      end
    join
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Mid-frame reset during data bit 3, with a second byte queued
    send = 1'b1; data_in = 8'h81;
    @(negedge clk);
    data_in = 8'h42;
    @(negedge clk);
    send = 1'b0;
    repeat (4 * DIV + 100 - 1) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0; send = 1'b1; data_in = 8'h99;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_fin", 32'(finished_send), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; send = 1'b0;
    bad = 0;
    repeat (FRAME + 800) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || finished_send !== 1'b0) bad++;
    end
    chk("after_rst_quiet", 32'(bad), 32'd0);

    // Loopback through a bench-side receiver sampling at mid-bit
    send = 1'b1; data_in = 8'h3C;
    @(negedge clk);
    send = 1'b0;
    cnt = 0;
    while (tx !== 1'b0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("rx_start_found", 32'(tx), 32'd0);
    repeat (DIV / 2) @(negedge clk);
    chk("rx_start_mid", 32'(tx), 32'd0);
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      rx[i] = tx;
    end
    repeat (DIV) @(negedge clk);
    chk("rx_stop_mid", 32'(tx), 32'd1);
    fin_seen = 1'b0;
    for (int i = 0; i < DIV && !fin_seen; i++) begin
      if (finished_send === 1'b1) fin_seen = 1'b1;
      @(negedge clk);
    end
    chk("rx_data_out", 32'(rx), 32'h3C);
    chk("rx_finished", 32'(fin_seen), 32'd1);
    repeat (DIV) @(negedge clk);
    chk("rx_idle_tx", 32'(tx), 32'd1);
    chk("rx_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
